// File: rtl/serial_sub4.sv
// ---------------------------------------------------------------------------
// serial_sub4 -- bit-serial subtractor, F = A - B - Bin (modulo 2^WIDTH)
//
// Operands are captured on an accepted start. A single full-subtractor cell
// then processes one bit per clock, LSB first, for WIDTH cycles. F and Bout
// are loaded once, on the final shift, and are held until the next result
// replaces them.
//
// Optional feature: define SUB_OVF_EN to add port V, the two's-complement
// overflow flag of the subtraction.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      launch request, accepted only in IDLE or DONE
//   A      in   WIDTH  minuend, captured on accepted start
//   B      in   WIDTH  subtrahend, captured on accepted start
//   Bin    in   1      borrow-in, captured on accepted start
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse when F/Bout are valid
//   F      out  WIDTH  difference, held until the next result
//   Bout   out  1      borrow-out (1 = A < B+Bin unsigned)
//   V      out  1      signed overflow (only with SUB_OVF_EN)
// ---------------------------------------------------------------------------
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             Bout
`ifdef SUB_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic            load, shift_en, last_bit;

    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic             br_reg;
    logic [CW-1:0]    count;

    // Full-subtractor cell on the current LSBs.
    logic a_bit, b_bit, d_bit, br_next;

    assign a_bit   = a_reg[0];
    assign b_bit   = b_reg[0];
    assign d_bit   = a_bit ^ b_bit ^ br_reg;
    assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);

    assign last_bit = (count == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand shift registers, partial result, borrow and count.
    // NOTE: the shift registers are reset along with the control state so
    // that an aborted operation leaves no stale operand bits behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            br_reg  <= 1'b0;
            count   <= '0;
        end else if (load) begin
            a_reg   <= A;
            b_reg   <= B;
            res_reg <= '0;
            br_reg  <= Bin;
            count   <= '0;
        end else if (shift_en) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            res_reg <= {d_bit, res_reg[WIDTH-1:1]};
            br_reg  <= br_next;
            count   <= count + 1'b1;
        end
    end

    // Result registers: loaded only on the final shift, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F    <= '0;
            Bout <= 1'b0;
        end else if (shift_en && last_bit) begin
            F    <= {d_bit, res_reg[WIDTH-1:1]};
            Bout <= br_next;
        end
    end

`ifdef SUB_OVF_EN
    // On the final shift a_bit/b_bit are the captured operand MSBs and
    // d_bit is the result MSB, so overflow is available without extra state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            V <= 1'b0;
        end else if (shift_en && last_bit) begin
            V <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
        end
    end
`endif

endmodule

// File: tb/tb_serial_sub4.sv
// ---------------------------------------------------------------------------
// tb_serial_sub4 -- directed self-checking bench for serial_sub4 (WIDTH=4).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// Define SUB_OVF_EN for both RTL and bench to exercise port V.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_sub4;

    localparam int WIDTH = 4;
    localparam int MAX_CYC = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Bin = 1'b0;
    logic             busy, done, Bout;
    logic [WIDTH-1:0] F;
`ifdef SUB_OVF_EN
    logic             V;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_sub4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .F     (F),
        .Bout  (Bout)
`ifdef SUB_OVF_EN
        ,
        .V     (V)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one operation, scramble the inputs after capture, then wait
    // for done and check latency, busy length, result and single pulse.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input logic [WIDTH-1:0] exp_f, input logic exp_b);
        int edges;
        int busy_cnt;
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
        busy_cnt = 0;
        while (!done && edges < MAX_CYC) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, " latency"}, edges, WIDTH + 1);
        check({tag, " busy_len"}, busy_cnt, WIDTH);
        check({tag, " F"}, F, exp_f);
        check({tag, " Bout"}, Bout, exp_b);
        @(negedge clk);
        check({tag, " done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int dones;
        int edges;
        logic [WIDTH-1:0] f_seen;

        // Reset state
        #12;
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst F", F, 4'h0);
        check("rst Bout", Bout, 1'b0);
`ifdef SUB_OVF_EN
        check("rst V", V, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Basic subtraction cases
        run_op("9-3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
        run_op("3-9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
        run_op("15-15", 4'd15, 4'd15, 1'b0, 4'h0, 1'b0);

        // start pulsed 2 cycles into SHIFT must be ignored
        @(negedge clk);
        A = 4'd12; B = 4'd5; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        A = 4'd1; B = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        f_seen = '0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                dones++;
                f_seen = F;
            end
            @(negedge clk);
        end
        check("ignore done_count", dones, 1);
        check("ignore F", f_seen, 4'd7);
        check("ignore Bout", Bout, 1'b0);

        // Back-to-back: start held through DONE
        @(negedge clk);
        A = 4'd14; B = 4'd4; Bin = 1'b0; start = 1'b1;
        edges = 0;
        while (!done && edges < MAX_CYC) begin
            @(negedge clk);
            edges++;
        end
        check("b2b first_done", done, 1'b1);
        check("b2b first F", F, 4'd10);
        A = 4'd7; B = 4'd2;
        @(negedge clk);
        start = 1'b0;
        check("b2b no_idle busy", busy, 1'b1);
        check("b2b hold F", F, 4'd10);
        @(negedge clk);
        check("b2b hold F mid", F, 4'd10);
        edges = 0;
        while (!done && edges < MAX_CYC) begin
            @(negedge clk);
            edges++;
        end
        check("b2b second_done", done, 1'b1);
        check("b2b second F", F, 4'd5);
        check("b2b second Bout", Bout, 1'b0);

        // Borrow-in wraparound, leaves nonzero F/Bout for the reset test
        run_op("0-0-1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);

        // Reset in SHIFT cycle 2 aborts immediately
        @(negedge clk);
        A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort F", F, 4'h0);
        check("abort Bout", Bout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no_done", dones, 0);

`ifdef SUB_OVF_EN
        run_op("ovf 8-1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0);
        check("ovf 8-1 V", V, 1'b1);
        run_op("ovf 5-2", 4'd5, 4'd2, 1'b0, 4'd3, 1'b0);
        check("ovf 5-2 V", V, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
